// File: rtl/mio_bus_hs.sv
// CPU-side bus handshake bridge: decodes each request to data RAM or to a 64-byte IO window.
// Optional macro MIO_TIMEOUT_EN adds an IO wait limit that ends the access with an error.
module mio_bus_hs #(
    parameter int unsigned RAM_AW  = 7,
    parameter int unsigned NUM_IO  = 4,
    parameter logic [31:0] IO_BASE = 32'hffff0000,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cpu_req,
    input  logic [1:0]           cpu_we,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wdata,
    output logic [31:0]          cpu_rdata,
    output logic                 cpu_ready,
    output logic                 cpu_err,
    output logic [RAM_AW-1:0]    ram_addr,
    output logic [31:0]          ram_wdata,
    output logic [1:0]           ram_we,
    input  logic [31:0]          ram_rdata,
    output logic [NUM_IO-1:0]    io_sel,
    output logic [1:0]           io_we,
    output logic [31:0]          io_wdata,
    input  logic [32*NUM_IO-1:0] io_rdata,
    input  logic [NUM_IO-1:0]    io_ack
);

    localparam int unsigned DW = 32;

    if (NUM_IO < 1 || NUM_IO > 16 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
        $error("mio_bus_hs: NUM_IO or TIMEOUT out of range");
    end

    typedef enum logic [1:0] {IDLE, RAM_RD, IO_WAIT, DONE} state_t;

    state_t        state;
    logic [DW-1:0] wdata_q;

    logic          is_io_c;
    logic          io_mapped_c;
    logic [3:0]    ch_idx_c;
    logic          sel_ack_c;
    logic [DW-1:0] sel_rdata_c;
    logic          unused_addr_c;

`ifdef MIO_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wait_cnt;
`endif

    assign is_io_c       = (cpu_addr[31:6] == IO_BASE[31:6]);
    assign ch_idx_c      = cpu_addr[5:2];
    assign io_mapped_c   = (32'(ch_idx_c) < NUM_IO);
    assign unused_addr_c = ^cpu_addr[1:0];

    assign ram_wdata = wdata_q;
    assign io_wdata  = wdata_q;

    // Ack and read data of the currently selected channel; others are ignored.
    always_comb begin
        sel_ack_c   = 1'b0;
        sel_rdata_c = '0;
        for (int k = 0; k < NUM_IO; k++) begin
            if (io_sel[k]) begin
                sel_ack_c   = io_ack[k];
                sel_rdata_c = io_rdata[k*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            wdata_q   <= '0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            ram_addr  <= '0;
            ram_we    <= '0;
            io_sel    <= '0;
            io_we     <= '0;
`ifdef MIO_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            ram_we    <= '0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        if (is_io_c) begin
                            if (io_mapped_c) begin
                                wdata_q <= cpu_wdata;
                                io_sel  <= NUM_IO'(1) << ch_idx_c;
                                io_we   <= cpu_we;
                                state   <= IO_WAIT;
                            end else begin
                                // Unmapped channel: error completion, nothing else touched
                                cpu_ready <= 1'b1;
                                cpu_err   <= 1'b1;
                            end
                        end else if (cpu_we != 2'b00) begin
                            wdata_q   <= cpu_wdata;
                            ram_addr  <= cpu_addr[RAM_AW+1:2];
                            ram_we    <= cpu_we;
                            cpu_ready <= 1'b1;
                        end else begin
                            ram_addr <= cpu_addr[RAM_AW+1:2];
                            state    <= RAM_RD;
                        end
                    end
                end
                RAM_RD: begin
                    cpu_rdata <= ram_rdata;
                    cpu_ready <= 1'b1;
                    state     <= DONE;
                end
                IO_WAIT: begin
                    if (sel_ack_c) begin
                        if (io_we == 2'b00) begin
                            cpu_rdata <= sel_rdata_c;
                        end
                        io_sel    <= '0;
                        io_we     <= '0;
                        cpu_ready <= 1'b1;
                        state     <= DONE;
`ifdef MIO_TIMEOUT_EN
                        wait_cnt  <= '0;
                    end else if (wait_cnt == TO_LAST) begin
                        io_sel    <= '0;
                        io_we     <= '0;
                        cpu_ready <= 1'b1;
                        cpu_err   <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= DONE;
                    end else begin
                        wait_cnt  <= wait_cnt + 8'd1;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mio_bus_hs.sv
// Bench for mio_bus_hs: directed vector table, mid-access reset, then random traffic
// checked against a transaction-level reference model.
module tb_mio_bus_hs;

    localparam int unsigned RAM_AW  = 7;
    localparam int unsigned NUM_IO  = 4;
    localparam logic [31:0] IO_BASE = 32'hffff0000;
    localparam int unsigned TIMEOUT = 15;
    localparam int          BUDGET  = 60;

    logic                 clk;
    logic                 rstn;
    logic                 cpu_req;
    logic [1:0]           cpu_we;
    logic [31:0]          cpu_addr;
    logic [31:0]          cpu_wdata;
    logic [31:0]          cpu_rdata;
    logic                 cpu_ready;
    logic                 cpu_err;
    logic [RAM_AW-1:0]    ram_addr;
    logic [31:0]          ram_wdata;
    logic [1:0]           ram_we;
    logic [31:0]          ram_rdata;
    logic [NUM_IO-1:0]    io_sel;
    logic [1:0]           io_we;
    logic [31:0]          io_wdata;
    logic [32*NUM_IO-1:0] io_rdata;
    logic [NUM_IO-1:0]    io_ack;

    mio_bus_hs #(
        .RAM_AW(RAM_AW), .NUM_IO(NUM_IO), .IO_BASE(IO_BASE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rstn(rstn), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .io_sel(io_sel), .io_we(io_we), .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment: word RAM and per-channel IO read data
    logic [31:0] mem [0:2**RAM_AW-1];
    logic [31:0] chan_data [NUM_IO];
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) if (ram_we != 2'b00) mem[ram_addr] <= ram_wdata;
    for (genvar k = 0; k < NUM_IO; k++) begin : g_io
        assign io_rdata[32*k +: 32] = chan_data[k];
    end

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] rdata;
        logic [3:0]  sel;
        int          sel_cyc;
        logic [1:0]  io_we;
        logic [31:0] io_wd;
        int          wr_cnt;
        logic [1:0]  wr_we;
        logic [6:0]  wr_addr;
        logic [31:0] wr_data;
    } exp_t;

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] rdata;
        logic [3:0]  sel_val;
        int          sel_cyc;
        logic        sel_stable;
        logic [1:0]  iowe;
        logic [31:0] iowd;
        int          wr_cnt;
        logic [1:0]  wr_we;
        logic [6:0]  wr_addr;
        logic [31:0] wr_data;
        logic        after_ready;
        logic [3:0]  sel_after;
    } obs_t;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  we;
        logic [31:0] wd;
        int          dly;
        exp_t        e;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] ref_rdata;
    logic [31:0] ref_mem [int];

    function automatic logic [31:0] mem_init(input int i);
        return 32'hCAFE_0000 + 32'(i) - 32'd1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input logic [1:0] we, input logic [31:0] wd,
                                input int dly, input int lat, input logic err, input logic [31:0] rdata,
                                input logic [3:0] sel, input int sel_cyc, input int wr_addr);
        vec_t v;
        v.addr = addr; v.we = we; v.wd = wd; v.dly = dly;
        v.e = '{default: '0};
        v.e.lat = lat; v.e.err = err; v.e.rdata = rdata; v.e.sel = sel; v.e.sel_cyc = sel_cyc;
        if (sel_cyc > 0) begin
            v.e.io_we = we; v.e.io_wd = wd;
        end
        if (wr_addr >= 0) begin
            v.e.wr_cnt = 1; v.e.wr_we = we; v.e.wr_addr = 7'(wr_addr); v.e.wr_data = wd;
        end
        return v;
    endfunction

    // Transaction-level reference: classify the address and predict the outcome
    task automatic predict(input logic [31:0] addr, input logic [1:0] we, input logic [31:0] wd,
                           input int dly, output exp_t e);
        bit is_io;
        int idx, word;
        bit timed_out;
        is_io = (addr[31:6] == IO_BASE[31:6]);
        idx   = int'(addr[5:2]);
        word  = int'(addr[RAM_AW+1:2]);
        timed_out = 1'b0;
        e = '{default: '0};
        if (is_io && idx >= NUM_IO) begin
            e.lat = 1; e.err = 1'b1;
        end else if (is_io) begin
            e.sel = 4'(1 << idx); e.io_we = we; e.io_wd = wd;
`ifdef MIO_TIMEOUT_EN
            if (dly + 1 > TIMEOUT) timed_out = 1'b1;
`endif
            if (timed_out) begin
                e.lat = TIMEOUT + 1; e.err = 1'b1; e.sel_cyc = TIMEOUT;
            end else begin
                e.lat = dly + 2; e.sel_cyc = dly + 1;
                if (we == 2'b00) ref_rdata = chan_data[idx];
            end
        end else if (we != 2'b00) begin
            e.lat = 1; e.wr_cnt = 1; e.wr_we = we; e.wr_addr = 7'(word); e.wr_data = wd;
            ref_mem[word] = wd;
        end else begin
            e.lat = 2;
            ref_rdata = ref_mem.exists(word) ? ref_mem[word] : mem_init(word);
        end
        e.rdata = ref_rdata;
    endtask

    // Issue one request, act as the IO device, and record what the bus did
    task automatic do_txn(input logic [31:0] addr, input logic [1:0] we, input logic [31:0] wd,
                          input int dly, output obs_t o);
        o = '{default: '0};
        o.sel_stable = 1'b1;
        cpu_req = 1'b1; cpu_addr = addr; cpu_we = we; cpu_wdata = wd;
        for (int cyc = 1; cyc <= BUDGET; cyc++) begin
            step();
            cpu_req = 1'b0; cpu_addr = $urandom; cpu_we = 2'($urandom); cpu_wdata = $urandom;
            io_ack = NUM_IO'($urandom);
            if (io_sel != '0) begin
                o.sel_cyc++;
                if (o.sel_cyc == 1) begin
                    o.sel_val = io_sel; o.iowe = io_we; o.iowd = io_wdata;
                end else if (io_sel !== o.sel_val || io_we !== o.iowe || io_wdata !== o.iowd) begin
                    o.sel_stable = 1'b0;
                end
                if (o.sel_cyc == dly + 1) io_ack = io_ack | io_sel;
                else                      io_ack = io_ack & ~io_sel;
            end
            if (ram_we != 2'b00) begin
                o.wr_cnt++; o.wr_we = ram_we; o.wr_addr = ram_addr; o.wr_data = ram_wdata;
            end
            if (cpu_ready) begin
                o.lat = cyc; o.err = cpu_err; o.rdata = cpu_rdata;
                break;
            end
        end
        step();
        io_ack = '0;
        o.after_ready = cpu_ready;
        o.sel_after = io_sel;
    endtask

    task automatic cmp(input string tag, input exp_t e, input obs_t o);
        check({tag, " latency"}, 32'(o.lat), 32'(e.lat));
        check({tag, " cpu_err"}, 32'(o.err), 32'(e.err));
        check({tag, " cpu_rdata"}, o.rdata, e.rdata);
        check({tag, " io_sel cycles"}, 32'(o.sel_cyc), 32'(e.sel_cyc));
        if (e.sel_cyc > 0) begin
            check({tag, " io_sel"}, 32'(o.sel_val), 32'(e.sel));
            check({tag, " io_we"}, 32'(o.iowe), 32'(e.io_we));
            check({tag, " io_wdata"}, o.iowd, e.io_wd);
            check({tag, " io held"}, 32'(o.sel_stable), 32'd1);
        end
        check({tag, " ram_we cycles"}, 32'(o.wr_cnt), 32'(e.wr_cnt));
        if (e.wr_cnt > 0) begin
            check({tag, " ram_we"}, 32'(o.wr_we), 32'(e.wr_we));
            check({tag, " ram_addr"}, 32'(o.wr_addr), 32'(e.wr_addr));
            check({tag, " ram_wdata"}, o.wr_data, e.wr_data);
        end
        check({tag, " ready pulse"}, 32'(o.after_ready), 32'd0);
        check({tag, " io_sel after"}, 32'(o.sel_after), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " cpu_rdata"}, cpu_rdata, 32'd0);
        check({tag, " cpu_ready"}, 32'(cpu_ready), 32'd0);
        check({tag, " cpu_err"}, 32'(cpu_err), 32'd0);
        check({tag, " ram_we"}, 32'(ram_we), 32'd0);
        check({tag, " io_sel"}, 32'(io_sel), 32'd0);
        check({tag, " io_we"}, 32'(io_we), 32'd0);
    endtask

    initial begin
        vec_t  tbl [$];
        exp_t  e;
        obs_t  o;
        int    rdy_cnt;

        rstn = 1'b0; cpu_req = 1'b0; cpu_we = '0; cpu_addr = '0; cpu_wdata = '0; io_ack = '0;
        for (int i = 0; i < 2**RAM_AW; i++) mem[i] = mem_init(i);
        for (int k = 0; k < NUM_IO; k++) chan_data[k] = 32'h0000_00A4 + 32'(k);
        ref_rdata = '0;

        step();
        step();
        check_reset_vals("reset");
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cpu_addr = $urandom; cpu_we = 2'($urandom);
            step();
            check("idle cpu_ready", 32'(cpu_ready), 32'd0);
            check("idle io_sel", 32'(io_sel), 32'd0);
            check("idle ram_we", 32'(ram_we), 32'd0);
        end

        // addr, we, wdata, ack delay | latency, err, rdata, io_sel, io_sel cycles, ram write word
        tbl.push_back(mk(32'h0000_0010, 2'b01, 32'h1234_5678, 0, 1, 1'b0, 32'h0,         4'b0000, 0, 4));
        tbl.push_back(mk(32'h0000_0008, 2'b00, 32'h0,         0, 2, 1'b0, 32'hCAFE_0001, 4'b0000, 0, -1));
        tbl.push_back(mk(32'hffff_0004, 2'b00, 32'h0,         3, 5, 1'b0, 32'h0000_00A5, 4'b0010, 4, -1));
        tbl.push_back(mk(32'hffff_0020, 2'b00, 32'h0,         0, 1, 1'b1, 32'h0000_00A5, 4'b0000, 0, -1));
        tbl.push_back(mk(32'hffff_0008, 2'b11, 32'hDEAD_BEEF, 0, 2, 1'b0, 32'h0000_00A5, 4'b0100, 1, -1));
        tbl.push_back(mk(32'hffff_0000, 2'b00, 32'h0,         0, 2, 1'b0, 32'h0000_00A4, 4'b0001, 1, -1));
        tbl.push_back(mk(32'hffff_000c, 2'b00, 32'h0,         1, 3, 1'b0, 32'h0000_00A7, 4'b1000, 2, -1));
        tbl.push_back(mk(32'hffff_003c, 2'b10, 32'h55AA_55AA, 0, 1, 1'b1, 32'h0000_00A7, 4'b0000, 0, -1));
        tbl.push_back(mk(32'h0000_0000, 2'b00, 32'h0,         0, 2, 1'b0, 32'hCAFD_FFFF, 4'b0000, 0, -1));
        tbl.push_back(mk(32'hfffe_fffc, 2'b00, 32'h0,         0, 2, 1'b0, 32'hCAFE_007E, 4'b0000, 0, -1));
        tbl.push_back(mk(32'hffff_0040, 2'b11, 32'h0BAD_F00D, 0, 1, 1'b0, 32'hCAFE_007E, 4'b0000, 0, 16));
        tbl.push_back(mk(32'hffff_0040, 2'b00, 32'h0,         0, 2, 1'b0, 32'h0BAD_F00D, 4'b0000, 0, -1));

        foreach (tbl[i]) begin
            predict(tbl[i].addr, tbl[i].we, tbl[i].wd, tbl[i].dly, e);
            do_txn(tbl[i].addr, tbl[i].we, tbl[i].wd, tbl[i].dly, o);
            cmp($sformatf("vec%0d", i), tbl[i].e, o);
        end

`ifdef MIO_TIMEOUT_EN
        predict(32'hffff_0008, 2'b11, 32'h0000_1111, 1000, e);
        do_txn(32'hffff_0008, 2'b11, 32'h0000_1111, 1000, o);
        cmp("timeout", e, o);
        check("timeout lat", 32'(o.lat), 32'(TIMEOUT + 1));
`endif

        // Reset pulsed while the bridge waits on an IO ack
        cpu_req = 1'b1; cpu_addr = 32'hffff_0004; cpu_we = 2'b00;
        step();
        cpu_req = 1'b0; io_ack = '0;
        step();
        step();
        check("mid io_sel", 32'(io_sel), 32'b0010);
        #2 rstn = 1'b0;
        #1 check_reset_vals("async reset");
        step();
        rstn = 1'b1;
        rdy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (cpu_ready) rdy_cnt++;
        end
        check("aborted ready", 32'(rdy_cnt), 32'd0);
        ref_rdata = '0;
        predict(32'h0000_0008, 2'b00, 32'h0, 0, e);
        do_txn(32'h0000_0008, 2'b00, 32'h0, 0, o);
        cmp("post-reset read", e, o);

        for (int n = 0; n < 200; n++) begin
            logic [31:0] addr;
            logic [1:0]  we;
            int          dly;
            int          kind;
            for (int k = 0; k < NUM_IO; k++) chan_data[k] = $urandom;
            kind = int'($urandom_range(0, 9));
            if (kind < 5) begin
                addr = ($urandom & 32'hFFFF_FFC3) | (32'($urandom_range(0, 7)) << 2);
                if (addr[31:6] == IO_BASE[31:6]) addr[6] = ~addr[6];
            end else if (kind < 9) begin
                addr = {IO_BASE[31:6], 4'($urandom_range(0, NUM_IO - 1)), 2'($urandom)};
            end else begin
                addr = {IO_BASE[31:6], 4'($urandom_range(NUM_IO, 15)), 2'($urandom)};
            end
            we  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            dly = int'($urandom_range(0, 6));
`ifdef MIO_TIMEOUT_EN
            if ($urandom_range(0, 7) == 0) dly = int'($urandom_range(12, 20));
`endif
            predict(addr, we, $urandom, dly, e);
            do_txn(addr, we, e.wr_cnt > 0 ? e.wr_data : (e.sel_cyc > 0 ? e.io_wd : 32'h0), dly, o);
            cmp($sformatf("rnd%0d", n), e, o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
